// File: rtl/minv_ctrl_if.sv
// Controller <-> datapath bundle for the binary extended-Euclid inverter.
// master = sequencing controller, slave = datapath / flag register side.
interface minv_ctrl_if;
  // Handshake: start is a level sampled only while the controller is idle.
  // There is no backpressure. Every op_* output is a one-cycle command that
  // the datapath applies at the next rising edge. done/err are one-cycle pulses.
  logic       start;
  logic       u_one;
  logic       v_one;
  logic       u_even;
  logic       v_even;
  logic       u_ge_v;
  logic       op_ld;
  logic       op_u_half;
  logic       op_v_half;
  logic       op_u_sub;
  logic       op_v_sub;
  logic       op_t_copy;
  logic       t_src;
  logic [1:0] minv_flag_in;
  logic       minv_flag_we;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, u_one, v_one, u_even, v_even, u_ge_v,
    output op_ld, op_u_half, op_v_half, op_u_sub, op_v_sub, op_t_copy, t_src,
    output minv_flag_in, minv_flag_we, busy, done, err
  );

  modport slave (
    output start, u_one, v_one, u_even, v_even, u_ge_v,
    input  op_ld, op_u_half, op_v_half, op_u_sub, op_v_sub, op_t_copy, t_src,
    input  minv_flag_in, minv_flag_we, busy, done, err
  );
endinterface

// File: rtl/minv_ctrl.sv
// Sequencer for binary extended-Euclid modular inversion: one micro-op per cycle.
// Optional macro MINV_COPY_T_EN adds a COPY state that moves the result to regt.
module minv_ctrl #(
  parameter int MAX_ITER = 512,
  parameter int CW       = $clog2(MAX_ITER + 1)
) (
  input  logic        clk,
  input  logic        rst,
  minv_ctrl_if.master bus,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_COPY  = 3'd3,
    S_FIN   = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_iter;
  logic          r_sel;

  state_t        w_next;
  logic [CW-1:0] w_iter_next;
  logic          w_sel_next;
  logic          w_op_ld;
  logic          w_op_u_half;
  logic          w_op_v_half;
  logic          w_op_u_sub;
  logic          w_op_v_sub;
  logic          w_op_t_copy;
  logic          w_t_src;
  logic [1:0]    w_flag_in;
  logic          w_flag_we;
  logic          w_done;
  logic          w_err;
  state_t        w_conv_state;

`ifdef MINV_COPY_T_EN
  assign w_conv_state = S_COPY;
`else
  assign w_conv_state = S_FIN;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_iter  <= w_iter_next;
      r_sel   <= w_sel_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_iter_next = r_iter;
    w_sel_next  = r_sel;
    w_op_ld     = 1'b0;
    w_op_u_half = 1'b0;
    w_op_v_half = 1'b0;
    w_op_u_sub  = 1'b0;
    w_op_v_sub  = 1'b0;
    w_op_t_copy = 1'b0;
    w_t_src     = 1'b0;
    w_flag_in   = 2'b00;
    w_flag_we   = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next      = S_LOAD;
          w_iter_next = '0;
        end
      end
      S_LOAD: begin
        w_op_ld = 1'b1;
        w_next  = S_TEST;
      end
      S_TEST: begin
        // Convergence is tested ahead of the iteration limit on purpose.
        if (bus.u_one) begin
          w_sel_next = 1'b0;
          w_next     = w_conv_state;
        end else if (bus.v_one) begin
          w_sel_next = 1'b1;
          w_next     = w_conv_state;
        end else if (r_iter == CW'(MAX_ITER)) begin
          w_next = S_ABORT;
        end else begin
          w_iter_next = r_iter + CW'(1);
          if (bus.u_even)      w_op_u_half = 1'b1;
          else if (bus.v_even) w_op_v_half = 1'b1;
          else if (bus.u_ge_v) w_op_u_sub  = 1'b1;
          else                 w_op_v_sub  = 1'b1;
        end
      end
`ifdef MINV_COPY_T_EN
      S_COPY: begin
        w_op_t_copy = 1'b1;
        w_t_src     = r_sel;
        w_next      = S_FIN;
      end
`endif
      S_FIN: begin
        w_flag_we = 1'b1;
        w_done    = 1'b1;
`ifdef MINV_COPY_T_EN
        w_flag_in = 2'b11;
`else
        w_flag_in = {1'b0, r_sel};
`endif
        w_next    = S_IDLE;
      end
      S_ABORT: begin
        w_done = 1'b1;
        w_err  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.op_ld        = w_op_ld;
  assign bus.op_u_half    = w_op_u_half;
  assign bus.op_v_half    = w_op_v_half;
  assign bus.op_u_sub     = w_op_u_sub;
  assign bus.op_v_sub     = w_op_v_sub;
  assign bus.op_t_copy    = w_op_t_copy;
  assign bus.t_src        = w_t_src;
  assign bus.minv_flag_in = w_flag_in;
  assign bus.minv_flag_we = w_flag_we;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = w_done;
  assign bus.err          = w_err;
  assign o_state          = r_state;

endmodule

// File: tb/tb_minv_ctrl.sv
// Bench for minv_ctrl: modular datapath model, algorithm-level expected-cycle
// queue compared every cycle, plus literal pins for the documented vectors.
module tb_minv_ctrl;
  localparam int MAXIT = 16;
`ifdef MINV_COPY_T_EN
  localparam bit COPY_EN = 1'b1;
`else
  localparam bit COPY_EN = 1'b0;
`endif
  localparam int B_LD = 12, B_UH = 11, B_VH = 10, B_US = 9, B_VS = 8;
  localparam int B_TC = 7, B_TS = 6, B_FW = 3, B_BUSY = 2, B_DONE = 1, B_ERR = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  minv_ctrl_if bus();
  logic [2:0] dbg_state;
  minv_ctrl #(.MAX_ITER(MAXIT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_state(dbg_state)
  );

  logic [12:0] act_vec;
  assign act_vec = {bus.op_ld, bus.op_u_half, bus.op_v_half, bus.op_u_sub, bus.op_v_sub,
                    bus.op_t_copy, bus.t_src, bus.minv_flag_in, bus.minv_flag_we,
                    bus.busy, bus.done, bus.err};

  // datapath model: registered update, combinational status
  int dp_a = 0, dp_p = 7;
  int u = 5, v = 5, x1 = 0, x2 = 0, regt = 0;

  function automatic int half_mod(input int x, input int p);
    return (x % 2 == 0) ? x / 2 : (x + p) / 2;
  endfunction
  function automatic int sub_mod(input int a, input int b, input int p);
    return (a - b + p) % p;
  endfunction

  assign bus.u_one  = (u == 1);
  assign bus.v_one  = (v == 1);
  assign bus.u_even = (u % 2 == 0);
  assign bus.v_even = (v % 2 == 0);
  assign bus.u_ge_v = (u >= v);

  always @(posedge clk) begin
    if (bus.op_ld) begin
      u <= dp_a; v <= dp_p; x1 <= 1; x2 <= 0;
    end else if (bus.op_u_half) begin
      u <= u / 2; x1 <= half_mod(x1, dp_p);
    end else if (bus.op_v_half) begin
      v <= v / 2; x2 <= half_mod(x2, dp_p);
    end else if (bus.op_u_sub) begin
      u <= u - v; x1 <= sub_mod(x1, x2, dp_p);
    end else if (bus.op_v_sub) begin
      v <= v - u; x2 <= sub_mod(x2, x1, dp_p);
    end
    if (bus.op_t_copy) regt <= bus.t_src ? x2 : x1;
  end

  // scoreboard state
  logic [12:0] exp_q[$];
  int op_log[$];
  int ld_cycs[$];
  int done_cycs[$];
  int checks = 0, failures = 0;
  int flag_writes = 0, done_cnt = 0, t0 = 0;
  logic [1:0] last_flag = 2'b00;
  logic last_err = 1'b0;
  bit mdl_conv;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Algorithm-level model: list of per-cycle outputs from LOAD to done.
  task automatic model_run(input int a, input int p, input bit with_idle);
    logic [12:0] e;
    int mu, mv, m1, m2, n;
    bit sel;
    if (with_idle) exp_q.push_back(13'd0);
    e = 13'd0; e[B_LD] = 1'b1; e[B_BUSY] = 1'b1;
    exp_q.push_back(e);
    mu = a; mv = p; m1 = 1; m2 = 0; n = 0; sel = 1'b0;
    while (1) begin
      e = 13'd0; e[B_BUSY] = 1'b1;
      if (mu == 1 || mv == 1) begin sel = (mu != 1); exp_q.push_back(e); break; end
      if (n == MAXIT) begin exp_q.push_back(e); break; end
      if (mu % 2 == 0)      begin e[B_UH] = 1'b1; mu = mu / 2; m1 = half_mod(m1, p); end
      else if (mv % 2 == 0) begin e[B_VH] = 1'b1; mv = mv / 2; m2 = half_mod(m2, p); end
      else if (mu >= mv)    begin e[B_US] = 1'b1; mu = mu - mv; m1 = sub_mod(m1, m2, p); end
      else                  begin e[B_VS] = 1'b1; mv = mv - mu; m2 = sub_mod(m2, m1, p); end
      exp_q.push_back(e);
      n++;
    end
    mdl_conv = (mu == 1 || mv == 1);
    if (mdl_conv) begin
      if (COPY_EN) begin
        e = 13'd0; e[B_TC] = 1'b1; e[B_TS] = sel; e[B_BUSY] = 1'b1;
        exp_q.push_back(e);
      end
      e = 13'd0; e[B_FW] = 1'b1; e[B_BUSY] = 1'b1; e[B_DONE] = 1'b1;
      e[5:4] = COPY_EN ? 2'b11 : {1'b0, sel};
      exp_q.push_back(e);
    end else begin
      e = 13'd0; e[B_BUSY] = 1'b1; e[B_DONE] = 1'b1; e[B_ERR] = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_loop();
    logic [12:0] e;
    forever begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'd0;
      checks++;
      if (act_vec !== e) begin
        failures++;
        $display("FAIL cycle_outputs cyc=%0d actual=%b required=%b", cyc, act_vec, e);
      end
      if (act_vec[B_UH]) op_log.push_back(1);
      if (act_vec[B_VH]) op_log.push_back(2);
      if (act_vec[B_US]) op_log.push_back(3);
      if (act_vec[B_VS]) op_log.push_back(4);
      if (act_vec[B_LD]) ld_cycs.push_back(cyc);
      if (act_vec[B_DONE]) begin
        done_cycs.push_back(cyc); done_cnt++; last_err = act_vec[B_ERR];
      end
      if (act_vec[B_FW]) begin flag_writes++; last_flag = act_vec[5:4]; end
    end
  endtask

  // driver tasks
  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(negedge clk); #1; k++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start_run(input int a, input int p, input int pulse_at);
    dp_a = a; dp_p = p;
    op_log.delete(); ld_cycs.delete(); done_cycs.delete();
    model_run(a, p, 1'b0);
    t0 = cyc;
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    if (pulse_at > 0) begin
      repeat (pulse_at - 1) begin @(negedge clk); #1; end
      bus.start = 1'b1;
      @(negedge clk); #1;
      bus.start = 1'b0;
    end
    wait_drain();
    repeat (2) begin @(negedge clk); #1; end
  endtask

  function automatic int result_val();
    if (last_flag == 2'b11) return regt;
    return (last_flag == 2'b01) ? x2 : x1;
  endfunction

  task automatic check_inverse(input string name, input int a, input int p);
    check(name, (result_val() * a) % p, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    fork
      compare_loop();
      begin
        int fw0, dc0;
        #1 rst = 1'b1;
        #1 check("reset_outputs", int'(act_vec), 0);
        repeat (2) begin @(negedge clk); #1; end
        rst = 1'b0;
        repeat (2) begin @(negedge clk); #1; end

        // p=7, a=1: immediate convergence on u
        start_run(1, 7, 0);
        check("a1_done_cycle", done_cycs[0] - t0, COPY_EN ? 4 : 3);
        check("a1_flag_in", int'(last_flag), COPY_EN ? 3 : 0);
        check("a1_op_count", op_log.size(), 0);
        check_inverse("a1_inverse", 1, 7);

        // p=7, a=3: v_sub, v_half, v_half then converge on v
        start_run(3, 7, 0);
        check("a3_op_count", op_log.size(), 3);
        if (op_log.size() == 3) begin
          check("a3_op0_vsub", op_log[0], 4);
          check("a3_op1_vhalf", op_log[1], 2);
          check("a3_op2_vhalf", op_log[2], 2);
        end
        check("a3_done_cycle", done_cycs[0] - t0, COPY_EN ? 7 : 6);
        check("a3_flag_in", int'(last_flag), COPY_EN ? 3 : 1);
        check("a3_result", result_val(), 5);

        // a few more coprime operands, one with a start pulse while busy
        start_run(5, 11, 3);
        check("p11_single_done", done_cycs.size(), 1);
        check("p11_single_load", ld_cycs.size(), 1);
        check_inverse("p11_inverse", 5, 11);
        start_run(10, 13, 0);
        check_inverse("p13_inverse", 10, 13);
        start_run(2, 7, 0);
        check_inverse("p7a2_inverse", 2, 7);

        // non-coprime and a=0 never converge
        fw0 = flag_writes;
        start_run(6, 9, 0);
        check("gcd3_err", int'(last_err), 1);
        check("gcd3_no_flag_write", flag_writes, fw0);
        start_run(0, 7, 0);
        check("a0_op_count", op_log.size(), 16);
        check("a0_all_uhalf", op_log.sum() with (int'(item == 1)), 16);
        check("a0_done_cycle", done_cycs[0] - t0, 19);
        check("a0_err", int'(last_err), 1);
        check("a0_no_flag_write", flag_writes, fw0);

        // start held high: back-to-back inversions
        dp_a = 3; dp_p = 7;
        op_log.delete(); ld_cycs.delete(); done_cycs.delete();
        model_run(3, 7, 1'b0);
        model_run(3, 7, 1'b1);
        t0 = cyc;
        bus.start = 1'b1;
        wait_drain();
        bus.start = 1'b0;
        repeat (3) begin @(negedge clk); #1; end
        check("b2b_done_count", done_cycs.size(), 2);
        check("b2b_load_count", ld_cycs.size(), 2);
        if (ld_cycs.size() == 2 && done_cycs.size() >= 1)
          check("b2b_gap", ld_cycs[1] - done_cycs[0], 2);

        // asynchronous reset in the middle of TEST
        dp_a = 3; dp_p = 7;
        model_run(3, 7, 1'b0);
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        fw0 = flag_writes; dc0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outputs", int'(act_vec), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        exp_q.delete();
        repeat (2) begin @(negedge clk); #1; end
        rst = 1'b0;
        repeat (8) begin @(negedge clk); #1; end
        check("rst_mid_no_done", done_cnt, dc0);
        check("rst_mid_no_flag", flag_writes, fw0);

        // recovery after reset
        start_run(3, 7, 0);
        check_inverse("post_rst_inverse", 3, 7);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
